// File: rtl/if_stage.sv
// if_stage: instruction fetch stage. Holds the PC, issues word fetches over a
// valid/ready request channel and buffers in-order variable-latency responses.
// Ports: clk, rst (sync, active-high); imem_req_valid/ready/addr (request);
// imem_rsp_valid/data (response, no backpressure); redirect_valid/pc (PC
// redirect); stall (decode hold); valid_out/inst_out/pc_out (to decode);
// misalign_err (sticky misaligned-redirect flag).
// Optional macro IF_MISALIGN_CHECK_EN: flag misaligned redirects, halt fetch.
module if_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  misalign_err
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] pc;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop_cnt, drop_nxt;
    logic [CW-1:0]         rf_count;
    logic [PW-1:0]         pf_wr, pf_rd;
    logic [PW-1:0]         rf_wr, rf_rd;

    logic [ADDR_WIDTH-1:0] pf_mem  [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] rf_inst [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] rf_pc   [BUF_DEPTH];

    logic          halted;
    logic          req_fire;
    logic          rsp_keep;
    logic          out_free;
    logic          rf_empty;
    logic          bypass;
    logic          rf_push;
    logic          rf_pop;
    logic          credit_ok;
    logic [CW:0]   in_use;
    logic [ADDR_WIDTH-1:0] rsp_pc;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_set;

    assign misalign_set = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (misalign_set) begin
            misalign_err <= 1'b1;
        end
    end

    assign halted = misalign_err;
`else
    assign misalign_err = 1'b0;
    assign halted       = 1'b0;
`endif

    // Every outstanding request owns a response-FIFO slot, so the FIFO
    // can never overflow even when decode stalls indefinitely.
    assign in_use    = {1'b0, outstanding} + {1'b0, rf_count};
    assign credit_ok = in_use < (CW+1)'(BUF_DEPTH);

    assign imem_req_valid = !rst && credit_ok && !redirect_valid && !halted;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_pc   = pf_mem[pf_rd];
    assign out_free = !valid_out || !stall;
    assign rf_empty = (rf_count == '0);
    assign bypass   = rsp_keep && out_free && rf_empty;
    assign rf_push  = rsp_keep && !bypass;
    assign rf_pop   = out_free && !rf_empty && !redirect_valid;

    // Responses to the old stream are recognised purely by arrival order:
    // the first drop_cnt responses after a redirect are discarded.
    always_comb begin
        drop_nxt  = drop_cnt;
        rsp_keep  = 1'b0;
        if (redirect_valid) begin
            drop_nxt = outstanding - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid) begin
            unique case (state)
                RUN:   rsp_keep = 1'b1;
                DRAIN: drop_nxt = drop_cnt - CW'(1);
                default: rsp_keep = 1'b0;
            endcase
        end
        state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pf_mem[pf_wr] <= pc;
        end
        if (rf_push) begin
            rf_inst[rf_wr] <= imem_rsp_data;
            rf_pc[rf_wr]   <= rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            pf_wr       <= '0;
            pf_rd       <= '0;
            rf_wr       <= '0;
            rf_rd       <= '0;
            rf_count    <= '0;
            valid_out   <= 1'b0;
            inst_out    <= '0;
            pc_out      <= '0;
        end else begin
            drop_cnt    <= drop_nxt;
            outstanding <= outstanding + CW'(req_fire)
                         - CW'(imem_rsp_valid);
            if (req_fire) begin
                pf_wr <= pf_wr + PW'(1);
            end
            if (imem_rsp_valid) begin
                pf_rd <= pf_rd + PW'(1);
            end
            if (redirect_valid) begin
                pc        <= redirect_pc & ALIGN_MASK;
                rf_wr     <= '0;
                rf_rd     <= '0;
                rf_count  <= '0;
                valid_out <= 1'b0;
            end else begin
                if (req_fire) begin
                    pc <= pc + ADDR_WIDTH'(4);
                end
                if (rf_push) begin
                    rf_wr <= rf_wr + PW'(1);
                end
                if (rf_pop) begin
                    rf_rd <= rf_rd + PW'(1);
                end
                rf_count <= rf_count + CW'(rf_push) - CW'(rf_pop);
                if (out_free) begin
                    unique case (1'b1)
                        rf_pop: begin
                            valid_out <= 1'b1;
                            inst_out  <= rf_inst[rf_rd];
                            pc_out    <= rf_pc[rf_rd];
                        end
                        bypass: begin
                            valid_out <= 1'b1;
                            inst_out  <= imem_rsp_data;
                            pc_out    <= rsp_pc;
                        end
                        default: valid_out <= 1'b0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with a behavioural in-order
// instruction memory of programmable latency.
module tb_if_stage;
    localparam logic [31:0] K = 32'hA500_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        valid_out;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        misalign_err;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
        int          ep;
    } req_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    req_t        pend[$];
    exp_t        expq[$];
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          n_pass = 0;
    int          n_chk = 0;
    int          max_inflight = 0;
    bit          track = 0;
    logic [31:0] exp_pc = '0;

    if_stage #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .valid_out     (valid_out),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    // Memory: returns addr^K in request order, one response per cycle.
    always @(posedge clk) begin : mem
        req_t r;
        int   n;
        #2;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = r.addr ^ K;
            if (r.ep == epoch) expq.push_back('{r.addr ^ K, r.addr});
        end else begin
            imem_rsp_valid = 1'b0;
        end
        if (track) begin
            n = expq.size() + pend.size();
            if (n > max_inflight) max_inflight = n;
        end
    end

    // Request acceptor and address model.
    always @(negedge clk) begin
        if (!rst && imem_req_valid) begin
            check("req_addr", imem_req_addr, exp_pc);
            if (imem_req_ready) begin
                pend.push_back('{exp_pc, cyc + lat, epoch});
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    // Monitor: compares each instruction decode consumes.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && valid_out && !stall && !redirect_valid) begin
            if (expq.size() == 0) begin
                n_chk++;
                $display("FAIL out_unexpected: got pc %h want none", pc_out);
            end else begin
                e = expq.pop_front();
                check("out_pc", pc_out, e.pc);
                check("out_inst", inst_out, e.inst);
            end
        end
    end

    task automatic redirect(input logic [31:0] tgt, input logic st);
        @(posedge clk) #1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        stall          = st;
        epoch++;
        expq.delete();
        exp_pc = tgt & ~32'd3;
        @(posedge clk) #1;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        @(negedge clk);
        check("redir_valid_low", {31'd0, valid_out}, 32'd0);
    endtask

    task automatic wait_first(input string name, input logic [31:0] want);
        bit got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (valid_out && !stall) got = 1;
        end
        if (got) check(name, pc_out, want);
        else begin
            n_chk++;
            $display("FAIL %s: timeout got none want %h", name, want);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin : stim
        int  cnt;
        bit  ok;
        rst            = 1'b1;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        run(3);
        @(negedge clk);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_inst_out", inst_out, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);

        @(posedge clk) #1 rst = 1'b0;
        @(negedge clk);
        check("cyc0_valid_out", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        check("cyc1_valid_out", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        check("cyc2_valid_out", {31'd0, valid_out}, 32'd1);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid_out) cnt++;
        end
        check("stream_continuous", cnt, 32'd10);

        @(posedge clk) #1;
        stall        = 1'b1;
        track        = 1'b1;
        max_inflight = 0;
        run(5);
        #1;
        stall = 1'b0;
        track = 1'b0;
        check("stall_max_inflight", max_inflight, 32'd3);
        run(10);

        @(posedge clk) #1 imem_req_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("req_held_valid", {31'd0, imem_req_valid}, 32'd1);
        end
        @(posedge clk) #1 imem_req_ready = 1'b1;
        run(5);

        lat = 3;
        run(10);
        redirect(32'h0000_0100, 1'b0);
        wait_first("redir_first_pc", 32'h0000_0100);
        lat = 1;
        run(10);

        redirect(32'h0000_0200, 1'b1);
        wait_first("redir_stall_first_pc", 32'h0000_0200);
        run(8);

`ifdef IF_MISALIGN_CHECK_EN
        redirect(32'h0000_0102, 1'b0);
        check("misalign_set", {31'd0, misalign_err}, 32'd1);
        ok = 1;
        repeat (6) begin
            @(negedge clk);
            if (imem_req_valid !== 1'b0) ok = 0;
        end
        check("misalign_halt", {31'd0, ok}, 32'd1);
`else
        redirect(32'h0000_0102, 1'b0);
        check("misalign_off", {31'd0, misalign_err}, 32'd0);
        wait_first("misalign_off_pc", 32'h0000_0100);
        ok = 1;
`endif

        stall = 1'b0;
        cnt   = 0;
        @(posedge clk) #1 imem_req_ready = 1'b0;
        while ((expq.size() > 0 || pend.size() > 0) && cnt < 100) begin
            @(posedge clk);
            cnt++;
        end
        run(2);
        check("drain_leftover", expq.size() + pend.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage. Holds the program counter and issues sequential word fetches to instruction memory over a valid/ready request channel with in-order, variable-latency responses. Buffers returned instructions and presents them, with their PC, to the decode stage through a registered valid/stall interface. Accepts PC redirects from later stages and discards in-flight responses that belong to the old stream.

## Interface
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, PC / fetch address width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- BUF_DEPTH, 2, response buffer entries and max outstanding requests (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_WIDTH  fetch address (word aligned)
- imem_rsp_valid  in  1  response valid, in request order, no backpressure
- imem_rsp_data  in  DATA_WIDTH  fetched instruction
- redirect_valid  in  1  PC redirect (branch/jump taken)
- redirect_pc  in  ADDR_WIDTH  redirect target
- stall  in  1  decode cannot accept; hold outputs
- valid_out  out  1  inst_out/pc_out valid
- inst_out  out  DATA_WIDTH  instruction to decode (feeds decode `inst`)
- pc_out  out  ADDR_WIDTH  PC of inst_out
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: pc, outstanding count (0..BUF_DEPTH), drop count, response FIFO of {inst, pc} (BUF_DEPTH), in-flight PC FIFO (BUF_DEPTH), output register.
- Request issue: imem_req_valid=1 when outstanding + fifo_count < BUF_DEPTH, no redirect this cycle, not halted. Handshake (valid&ready): push pc into PC FIFO, pc += 4, outstanding++. Address held stable while valid&!ready.
- Response: imem_rsp_valid pops PC FIFO, outstanding--. If drop_cnt>0: discard, drop_cnt--. Else bypass into output register if output register is free or draining (valid_out=0 or stall=0) and response FIFO empty; otherwise push into response FIFO (never overflows by credit rule).
- Output register: when valid_out=0 or stall=0, load response-FIFO head (pop) or bypassed response; if neither, valid_out←0. When stall=1 and valid_out=1, hold all outputs.
- Redirect: pc←{redirect_pc[ADDR_WIDTH-1:2],2'b00}; response FIFO flushed; valid_out←0; drop_cnt←outstanding − (imem_rsp_valid this cycle); imem_req_valid forced 0 in redirect cycle. Redirect overrides stall and any same-cycle response.
- FSM: RUN (normal) and DRAIN (drop_cnt>0; requests to new pc permitted, surviving responses identified purely by order). DRAIN→RUN when drop_cnt reaches 0.

## Timing
- Reset (rst=1 at edge): pc=RESET_PC, outstanding=0, drop_cnt=0, FIFOs empty, FSM=RUN, valid_out=0, inst_out=0, pc_out=0, misalign_err=0, imem_req_valid=0 during rst. rst mid-operation abandons in-flight requests; responses arriving while rst=1 are ignored; responses to pre-reset requests arriving after rst are the memory's responsibility to suppress.
- First request: cycle after rst deasserts, addr=RESET_PC.
- Latency: response at edge N with free output register → valid_out=1 after edge N (1 cycle). Buffered responses leave one per cycle once stall drops.
- Redirect at edge N → valid_out=0 after N; first new request cycle N+1, addr=target.
- Throughput: 1 inst/cycle with single-cycle memory and BUF_DEPTH≥2.

## Configuration
- IF_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]≠0 sets misalign_err (sticky until rst), flushes as a normal redirect, then halts fetch (imem_req_valid=0) until rst.
- Undefined: low two bits silently cleared; misalign_err tied 0.

## Test plan
- Reset, ready=1, 1-cycle memory returning addr as data, stall=0 → addrs 0,4,8,…; valid_out continuous from cycle 2, inst_out==pc_out.
- Stall=1 for 5 cycles mid-stream → outputs frozen, exactly 2 requests outstanding/buffered max, no loss or duplicate after release.
- imem_req_ready=0 for 3 cycles → imem_req_addr stable, pc not advanced.
- 3-cycle memory, redirect to 0x100 with 2 outstanding → both old responses dropped, next valid_out pc_out=0x100.
- Redirect coincident with stall=1 and imem_rsp_valid=1 → valid_out=0 next cycle, response discarded.
- With IF_MISALIGN_CHECK_EN, redirect to 0x102 → misalign_err=1, imem_req_valid=0 until rst; without macro, fetch resumes at 0x100.
